// File: rtl/instr_encoder.sv
// Packs accepted control bundles into {opcode, operand} program words written from address 0 up.
// Latency 1 cycle from acceptance to wr_en; a pending word is held until wr_ready, 1 word/cycle streaming.
// Backpressure: in_ready drops while a word stalls or the last word is pending; INSTR_ENC_CHECK_EN enables the opcode legality check.
module instr_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int OPW   = 3,
    parameter int IMMW  = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  Branch,
    input  logic                  MemtoReg,
    input  logic                  MemWrite,
    input  logic                  ALUSrc,
    input  logic                  RegWrite,
    input  logic                  special,
    input  logic                  MemRead,
    input  logic                  Sign_extend,
    input  logic [OPW-1:0]        ALUOp,
    input  logic [IMMW-1:0]       operand,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [AW-1:0]         wr_addr,
    output logic [OPW+IMMW-1:0]   wr_data,
    output logic                  illegal,
    output logic [7:0]            err_count,
    output logic                  busy,
    output logic                  full
);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_FULL = 2'd2;
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [OPW+IMMW-1:0] wr_data_q, wr_data_d;
    logic                illegal_q, illegal_d;
    logic [7:0]          err_q, err_d;

    logic [7:0] ctrl;
    logic       wr_done;
    logic       last_pending;
    logic       accept;
    logic       bad;

    assign ctrl = {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, special, MemRead, Sign_extend};

`ifdef INSTR_ENC_CHECK_EN
    logic [2:0] op3;
    logic [7:0] exp_v;
    logic [7:0] exp_m;

    assign op3 = 3'(ALUOp);

    // Mask bits set to 0 are don't-care positions in the per-opcode table.
    always_comb begin
        exp_v = 8'h08;
        exp_m = 8'hFF;
        case (op3)
            3'b010:         exp_v = 8'h5E;
            3'b011: begin   exp_v = 8'h36; exp_m = 8'hBF; end
            3'b100:         exp_v = 8'h1D;
            3'b101,
            3'b110: begin   exp_v = 8'h08; exp_m = 8'hFE; end
            3'b111: begin   exp_v = 8'h95; exp_m = 8'hBF; end
            default: ;
        endcase
    end

    assign bad = (((ctrl ^ exp_v) & exp_m) != 8'h00);
`else
    logic ctrl_unused;
    assign ctrl_unused = ^ctrl;
    assign bad         = 1'b0;
`endif

    assign wr_done      = wr_en_q && wr_ready;
    assign last_pending = wr_en_q && (wr_addr_q == LAST);
    assign in_ready     = (state_q == S_RUN) && (!wr_en_q || wr_ready) && !last_pending;
    assign accept       = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        illegal_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_FULL: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    err_d   = 8'd0;
                end
            end
            S_RUN: begin
                // addr_q is the next address to hand out; it only moves once a word lands.
                if (wr_done) begin
                    wr_en_d = 1'b0;
                    if (wr_addr_q == LAST) state_d = S_FULL;
                    else                   addr_d  = addr_q + AW'(1);
                end
                if (accept) begin
                    if (bad) begin
                        illegal_d = 1'b1;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_d;
                        wr_data_d = {ALUOp, operand};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            illegal_q <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign illegal   = illegal_q;
    assign err_count = err_q;
    assign busy      = (state_q == S_RUN);
    assign full      = (state_q == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4); legality-check scenarios follow INSTR_ENC_CHECK_EN.
module tb_instr_encoder;

    localparam int AW = 8;

    logic          Clk, Reset, start, in_valid, in_ready;
    logic          Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, special, MemRead, Sign_extend;
    logic [2:0]    ALUOp;
    logic [5:0]    operand;
    logic          wr_en, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic          illegal, busy, full;
    logic [7:0]    err_count;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] log_addr[$];
    logic [8:0]    log_data[$];

    instr_encoder #(.AW(AW), .DEPTH(4), .OPW(3), .IMMW(6)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .special(special), .MemRead(MemRead), .Sign_extend(Sign_extend),
        .ALUOp(ALUOp), .operand(operand), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .illegal(illegal), .err_count(err_count),
        .busy(busy), .full(full)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        if (Reset && wr_en && wr_ready) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] op, input logic [7:0] ctl, input logic [5:0] opd);
        {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, special, MemRead, Sign_extend} = ctl;
        ALUOp   = op;
        operand = opd;
    endtask

    task automatic do_reset();
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk) Reset = 1'b0;
        @(negedge Clk) Reset = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
        set_bundle(3'b000, 8'h00, 6'h00);
        #12;
        tests++; if (wr_en !== 1'b0)     begin fails++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
        tests++; if (wr_addr !== 8'h00)  begin fails++; $display("FAIL reset_wr_addr got %0h want 0", wr_addr); end
        tests++; if (wr_data !== 9'h000) begin fails++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        tests++; if ({busy, full, illegal} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, full, illegal}); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err got %0d want 0", err_count); end
        @(negedge Clk) Reset = 1'b1;
        step();
        tests++; if ({busy, in_ready} !== 2'b00) begin fails++; $display("FAIL idle_no_start got %b want 00", {busy, in_ready}); end
    endtask

    task automatic test_basic();
        log_addr.delete(); log_data.delete();
        wr_ready = 1'b1;
        do_start();
        tests++; if ({busy, full, in_ready} !== 3'b101) begin fails++; $display("FAIL basic_run got %b want 101", {busy, full, in_ready}); end
        set_bundle(3'b000, 8'h08, 6'h15);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (wr_en !== 1'b1)     begin fails++; $display("FAIL basic_wr_en got %0b want 1", wr_en); end
        tests++; if (wr_addr !== 8'h00)  begin fails++; $display("FAIL basic_addr got %0h want 0", wr_addr); end
        tests++; if (wr_data !== 9'h015) begin fails++; $display("FAIL basic_data got %0h want 015", wr_data); end
        step();
        tests++; if (wr_en !== 1'b0)     begin fails++; $display("FAIL basic_clear got %0b want 0", wr_en); end
        tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL basic_writes got %0d want 1", log_addr.size()); end
    endtask

    task automatic test_stall();
        log_addr.delete(); log_data.delete();
        wr_ready = 1'b0;
        set_bundle(3'b100, 8'h1D, 6'h2A);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h01, 9'h12A}) begin fails++; $display("FAIL stall_hold c%0d got %0b/%0h/%0h want 1/01/12a", i, wr_en, wr_addr, wr_data); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready c%0d got %0b want 0", i, in_ready); end
            step();
        end
        wr_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (log_addr.size() != 1 || log_addr[0] !== 8'h01) begin fails++; $display("FAIL stall_one_write got n=%0d want 1 at addr 1", log_addr.size()); end
        tests++; if ({wr_en, wr_addr} !== {1'b1, 8'h02}) begin fails++; $display("FAIL stall_next got %0b/%0h want 1/02", wr_en, wr_addr); end
        step();
    endtask

    task automatic test_full();
        do_reset();
        do_start();
        log_addr.delete(); log_data.delete();
        wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_bundle(3'b000, 8'h08, 6'(i));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        tests++; if (log_addr.size() != 4) begin fails++; $display("FAIL full_count got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            tests++; if (log_addr[i] !== 8'(i) || log_data[i] !== 9'(i)) begin fails++; $display("FAIL full_word%0d got %0h/%0h want %0h/%0h", i, log_addr[i], log_data[i], i, i); end
        end
        tests++; if ({full, busy, in_ready, wr_en} !== 4'b1000) begin fails++; $display("FAIL full_state got %b want 1000", {full, busy, in_ready, wr_en}); end
        do_start();
        tests++; if ({busy, full} !== 2'b10) begin fails++; $display("FAIL restart_state got %b want 10", {busy, full}); end
        set_bundle(3'b000, 8'h08, 6'h3F);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h00, 9'h03F}) begin fails++; $display("FAIL restart_write got %0b/%0h/%0h want 1/00/03f", wr_en, wr_addr, wr_data); end
        step();
    endtask

`ifdef INSTR_ENC_CHECK_EN
    task automatic test_check();
        do_reset();
        do_start();
        log_addr.delete(); log_data.delete();
        wr_ready = 1'b1;
        set_bundle(3'b111, 8'h15, 6'h07);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if ({illegal, wr_en} !== 2'b10) begin fails++; $display("FAIL chk_pulse got %b want 10", {illegal, wr_en}); end
        tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL chk_err1 got %0d want 1", err_count); end
        step();
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL chk_one_cycle got %0b want 0", illegal); end
        set_bundle(3'b111, 8'h95, 6'h07);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h00, 9'h1C7}) begin fails++; $display("FAIL chk_legal got %0b/%0h/%0h want 1/00/1c7", wr_en, wr_addr, wr_data); end
        step();
        set_bundle(3'b111, 8'h15, 6'h07);
        in_valid = 1'b1;
        repeat (300) step();
        in_valid = 1'b0;
        step();
        tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL chk_saturate got %0d want 255", err_count); end
        tests++; if (log_addr.size() != 1) begin fails++; $display("FAIL chk_writes got %0d want 1", log_addr.size()); end
    endtask
`else
    task automatic test_nocheck();
        do_reset();
        do_start();
        wr_ready = 1'b1;
        set_bundle(3'b111, 8'h15, 6'h07);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h00, 9'h1C7}) begin fails++; $display("FAIL nochk_write got %0b/%0h/%0h want 1/00/1c7", wr_en, wr_addr, wr_data); end
        tests++; if ({illegal, err_count} !== 9'd0) begin fails++; $display("FAIL nochk_err got %0b/%0d want 0/0", illegal, err_count); end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        do_start();
        wr_ready = 1'b0;
        set_bundle(3'b010, 8'h5E, 6'h11);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mid_pending got %0b want 1", wr_en); end
        #2 Reset = 1'b0;
        #1;
        tests++; if ({wr_en, wr_addr, wr_data, in_ready, busy, full, illegal, err_count} !== 30'd0) begin
            fails++; $display("FAIL mid_reset got %0b/%0h/%0h/%0b/%0b/%0b/%0b/%0d want all 0", wr_en, wr_addr, wr_data, in_ready, busy, full, illegal, err_count);
        end
        Reset = 1'b1;
        log_addr.delete(); log_data.delete();
        wr_ready = 1'b1;
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        tests++; if (log_addr.size() != 0 || wr_en !== 1'b0) begin fails++; $display("FAIL mid_no_write got n=%0d wr_en=%0b want 0/0", log_addr.size(), wr_en); end
        tests++; if ({busy, in_ready} !== 2'b00) begin fails++; $display("FAIL mid_idle got %b want 00", {busy, in_ready}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
`ifdef INSTR_ENC_CHECK_EN
        test_check();
`else
        test_nocheck();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameters: AW, 8, instruction-memory address width; DEPTH, 256, words per program (2..2^AW); OPW, 3, opcode/ALUOp width; IMMW, 6, operand width.
REQ-002 SHALL have ports, clock and reset first: Clk  in  1  clock; Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  begin program load at address 0; in_valid  in  1  control bundle offered; in_ready  out  1  bundle accepted when in_valid and in_ready are both high.
REQ-004 SHALL have ports: Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, special, MemRead, Sign_extend  in  1 each  control bundle; ALUOp  in  OPW  ALU operation; operand  in  IMMW  instruction operand field.
REQ-005 SHALL have ports: wr_en  out  1  word valid; wr_ready  in  1  memory accepts word; wr_addr  out  AW; wr_data  out  OPW+IMMW  {opcode, operand}.
REQ-006 SHALL have ports: illegal  out  1  one-cycle rejected-bundle pulse; err_count  out  8  rejected count; busy  out  1  state is RUN; full  out  1  state is FULL.

Function
REQ-007 SHALL implement states IDLE, RUN and FULL, with transitions IDLE->RUN on start, RUN->FULL when the word at address DEPTH-1 completes (wr_en and wr_ready), and FULL->RUN on start.
REQ-008 SHALL reset the address to 0 on every start-triggered entry to RUN; start SHALL be ignored while in RUN.
REQ-009 SHALL drive in_ready = RUN and (not wr_en or wr_ready) and not (wr_en and wr_addr==DEPTH-1).
REQ-010 SHALL encode an accepted bundle with opcode = ALUOp, registering wr_en=1, wr_data={opcode,operand} and wr_addr=current address on the next clock edge (1-cycle latency).
REQ-011 SHALL hold wr_en, wr_addr and wr_data stable until wr_ready is high; the address SHALL increment by 1 on each completed write.
REQ-012 SHALL clear wr_en after a completed write in the same cycle unless a new bundle is accepted in that cycle, so back-to-back throughput is 1 word/cycle.
REQ-013 SHALL never write an address at or beyond DEPTH and SHALL never wrap to 0 without a start.
REQ-014 SHALL keep illegal, err_count and the address unchanged in IDLE and FULL.

Reset
REQ-015 SHALL, while Reset is low, asynchronously force state IDLE, address 0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, illegal=0, err_count=0, busy=0, full=0.
REQ-016 SHALL discard any pending word when Reset is asserted mid-write; no write is completed after reset.

Configuration
REQ-017 SHALL, with INSTR_ENC_CHECK_EN defined, check each accepted bundle against the per-opcode table (bit order Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, special, MemRead, Sign_extend; x = ignored): 000 00001000; 001 00001000; 010 01011110; 011 0x110110; 100 00011101; 101 0000100x; 110 0000100x; 111 1x010101.
REQ-018 SHALL, with INSTR_ENC_CHECK_EN defined, drop a mismatching bundle (no write, no address increment), pulse illegal one cycle after acceptance, and increment err_count saturating at 255; err_count SHALL clear on start.
REQ-019 SHALL, without INSTR_ENC_CHECK_EN, ignore all control bits except ALUOp, tie illegal and err_count to 0, and write every accepted bundle.

Verification
REQ-020 SHALL cover: reset, start, then in_valid with ALUOp=000, RegWrite=1, operand=6'h15 and wr_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=9'h015.
REQ-021 SHALL cover: wr_ready held at 0 for 3 cycles while in_valid stays high -> wr_data and wr_addr stable, in_ready=0, and one write completes when wr_ready rises.
REQ-022 SHALL cover: DEPTH=4, stream 6 bundles -> addresses 0..3 written, full=1, in_ready=0; start -> busy=1 and next write at address 0.
REQ-023 SHALL cover, with the macro defined: the beq bundle with Branch=0 -> illegal pulse, no wr_en, err_count=1; 300 bad bundles -> err_count=255.
REQ-024 SHALL cover: Reset driven low while wr_en=1 and wr_ready=0 -> all outputs 0 immediately; after release, no write until start.
